partition_sweep_checker: RTL and testbench
==========================================

Name: partition_sweep_checker

Overview:
- Synthesizable exhaustive-sweep harness for approximate-logic partitions.
- Drives all 2^NUM_IN input patterns, in ascending order, into an approximate partition and its exact golden partition.
- Compares the two responses after a configurable pipeline latency and accumulates error metrics.
- Generalises the fixed-width, display-only partition testbench into an in-fabric checker with a start/done handshake.

Parameters:
NUM_IN, 7, partition input width (pattern count = 2^NUM_IN); legal range 1..20
NUM_OUT, 4, partition output width
PIPE_LAT, 0, cycles between a pattern on pi_o and its valid response on the po inputs; legal range 0..15
ERR_W, 32, width of the err_count and bit_flips accumulators

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  sweep request; single-cycle or level
pi_o  output  NUM_IN  pattern driven to both partitions
po_approx_i  input  NUM_OUT  approximate partition response
po_exact_i  input  NUM_OUT  golden partition response
busy  output  1  sweep or drain in progress
done  output  1  results valid; held until the next accepted start
err_count  output  ERR_W  number of patterns with approx != exact
bit_flips  output  ERR_W  total Hamming distance over all patterns
max_abs_err  output  NUM_OUT  maximum unsigned |approx - exact|
trace_valid  output  1  trace strobe (optional feature)
trace_pi  output  NUM_IN  pattern being compared (optional feature)
trace_po  output  NUM_OUT  approximate response being compared (optional feature)

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE. The latency valid pipeline is cleared. rst wins over every other event, including mid-sweep; no partial results are kept.
- FSM states: IDLE, SWEEP, DRAIN, DONE.
  - IDLE: on start=1, clear all accumulators and go to SWEEP with pi_o=0.
  - SWEEP: pi_o increments by 1 every cycle. In the cycle pi_o = 2^NUM_IN-1, the next state is DRAIN if PIPE_LAT>0, otherwise DONE. pi_o wraps to 0 on leaving SWEEP.
  - DRAIN: stays for exactly PIPE_LAT cycles while the last responses are compared, then goes to DONE.
  - DONE: done=1 and accumulators stable. start=1 clears the accumulators and re-enters SWEEP (same as IDLE).
- start is ignored while busy; no queuing.
- busy=1 in SWEEP and DRAIN only.
- Timing: if start is sampled at edge k:
  - pattern p is on pi_o during cycle k+1+p;
  - its response is sampled during cycle k+1+p+PIPE_LAT;
  - accumulators update at the end of that cycle;
  - done rises in cycle k+2^NUM_IN+PIPE_LAT+1.
- Comparison timing is tracked by a PIPE_LAT-deep valid shift register fed by (state==SWEEP). The po inputs are ignored when the tap is 0.
- Per valid compare:
  - d = popcount(approx ^ exact);
  - err_count += (d != 0);
  - bit_flips += d;
  - a = |approx - exact|, computed unsigned in NUM_OUT+1 bits and truncated to NUM_OUT; max_abs_err = max(max_abs_err, a).
- err_count and bit_flips saturate at 2^ERR_W-1 and never wrap.
- pi_o is registered; there is no combinational path from the po inputs to any output.

Optional Feature:
- Macro SWEEP_TRACE_EN.
- Defined: trace_valid pulses with each valid compare. trace_pi holds the compared pattern (delayed PIPE_LAT cycles with the valid bit) and trace_po holds po_approx_i, both registered with 1-cycle latency. This gives an on-chip equivalent of the per-pattern response dump.
- Undefined: the trace ports remain but are tied to 0. No delay-line storage for trace_pi is built.

Test Plan:
- Defaults; approx tied to exact; one-cycle start at edge k -> pi_o steps 0..127; done rises at cycle k+129; err_count=0, bit_flips=0, max_abs_err=0.
- Defaults; exact=pi_o[3:0], approx=exact^4'b0001 -> err_count=128, bit_flips=128, max_abs_err=1.
- Defaults; exact=pi_o[3:0], approx=0 -> err_count=120, bit_flips=256, max_abs_err=15.
- PIPE_LAT=2, both partitions modelled with 2-cycle registered delay, approx=exact^4'b1000 -> err_count=128, bit_flips=128, max_abs_err=8; done at k+131; the first 2 SWEEP cycles are not counted.
- ERR_W=4, approx always mismatching in all 4 bits -> err_count=15 and bit_flips=15, both saturated.
- Reset and start handling:
  - rst asserted at pi_o=50 -> all outputs 0 next cycle, FSM in IDLE;
  - start pulsed while busy -> ignored, no change in sweep timing;
  - start in DONE -> accumulators cleared and a fresh sweep with identical results.

Source files
------------

// File: rtl/partition_sweep_checker.sv
// partition_sweep_checker
//
// Exhaustive-sweep harness for approximate-logic partitions. On an accepted
// start it drives every NUM_IN-bit pattern, in ascending order, on pi_o to an
// approximate partition and its exact golden partition. Each pair of responses
// is compared PIPE_LAT cycles later, and the error metrics are accumulated.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            sweep request (pulse or level; ignored while busy)
//   pi_o             registered pattern driven to both partitions
//   po_approx_i      approximate partition response
//   po_exact_i       golden partition response
//   busy             sweep or drain in progress
//   done             results valid; held until the next accepted start
//   err_count        patterns with approx != exact (saturating)
//   bit_flips        total Hamming distance (saturating)
//   max_abs_err      maximum unsigned |approx - exact|
//   trace_valid/pi/po  per-compare trace strobe, pattern and approx response
//
// Optional feature macro: SWEEP_TRACE_EN. When it is defined, the trace ports
// carry a registered per-compare dump. When it is not defined, the trace ports
// are tied to 0 and the pattern delay line is not built.

module partition_sweep_checker #(
    parameter int NUM_IN   = 7,
    parameter int NUM_OUT  = 4,
    parameter int PIPE_LAT = 0,
    parameter int ERR_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [NUM_IN-1:0]  pi_o,
    input  logic [NUM_OUT-1:0] po_approx_i,
    input  logic [NUM_OUT-1:0] po_exact_i,
    output logic               busy,
    output logic               done,
    output logic [ERR_W-1:0]   err_count,
    output logic [ERR_W-1:0]   bit_flips,
    output logic [NUM_OUT-1:0] max_abs_err,
    output logic               trace_valid,
    output logic [NUM_IN-1:0]  trace_pi,
    output logic [NUM_OUT-1:0] trace_po
);

    localparam int D_W      = $clog2(NUM_OUT + 1);
    localparam bit NO_DRAIN = (PIPE_LAT == 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t             state;
    logic [3:0]         drain_cnt;
    logic               cmp_valid;
    logic               start_accept;

    logic [NUM_OUT-1:0] diff_bits;
    logic [D_W-1:0]     popcnt;
    logic [NUM_OUT-1:0] abs_err;
    logic [ERR_W:0]     flips_sum;

    // Compare strobe: the SWEEP flag delayed by PIPE_LAT cycles, so a compare
    // lines up with the response to the pattern driven PIPE_LAT cycles earlier.
    generate
        if (PIPE_LAT == 0) begin : g_vld_direct
            assign cmp_valid = (state == ST_SWEEP);
        end else begin : g_vld_pipe
            logic [PIPE_LAT-1:0] vld_sr;
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_sr <= '0;
                end else begin
                    vld_sr[0] <= (state == ST_SWEEP);
                    for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                        vld_sr[i] <= vld_sr[i-1];
                    end
                end
            end
            assign cmp_valid = vld_sr[PIPE_LAT-1];
        end
    endgenerate

    assign start_accept = start && ((state == ST_IDLE) || (state == ST_DONE));

    // Per-compare metrics. The absolute difference always fits in NUM_OUT bits,
    // so a magnitude-ordered subtraction matches the truncated NUM_OUT+1 form.
    always_comb begin
        diff_bits = po_approx_i ^ po_exact_i;
        popcnt    = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            popcnt = popcnt + D_W'(diff_bits[i]);
        end
        abs_err   = (po_approx_i >= po_exact_i) ? (po_approx_i - po_exact_i)
                                                : (po_exact_i - po_approx_i);
        flips_sum = {1'b0, bit_flips} + (ERR_W+1)'(popcnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pi_o        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            drain_cnt   <= '0;
            err_count   <= '0;
            bit_flips   <= '0;
            max_abs_err <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state <= ST_SWEEP;
                        pi_o  <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                ST_SWEEP: begin
                    // The last pattern wraps pi_o back to 0 by the increment itself.
                    pi_o <= pi_o + NUM_IN'(1);
                    if (pi_o == '1) begin
                        drain_cnt <= '0;
                        if (NO_DRAIN) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == 4'(PIPE_LAT - 1)) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase

            // Accumulators: cleared on an accepted start, updated on each valid
            // compare. Both counters saturate instead of wrapping.
            if (start_accept) begin
                err_count   <= '0;
                bit_flips   <= '0;
                max_abs_err <= '0;
            end else if (cmp_valid) begin
                if ((popcnt != '0) && (err_count != '1)) begin
                    err_count <= err_count + ERR_W'(1);
                end
                bit_flips <= flips_sum[ERR_W] ? '1 : flips_sum[ERR_W-1:0];
                if (abs_err > max_abs_err) begin
                    max_abs_err <= abs_err;
                end
            end
        end
    end

`ifdef SWEEP_TRACE_EN
    logic [NUM_IN-1:0] pi_tap;

    // Pattern delay line that travels alongside the compare strobe.
    generate
        if (PIPE_LAT == 0) begin : g_pi_direct
            assign pi_tap = pi_o;
        end else begin : g_pi_pipe
            logic [NUM_IN-1:0] pi_dly [PIPE_LAT];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int unsigned i = 0; i < PIPE_LAT; i++) begin
                        pi_dly[i] <= '0;
                    end
                end else begin
                    pi_dly[0] <= pi_o;
                    for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                        pi_dly[i] <= pi_dly[i-1];
                    end
                end
            end
            assign pi_tap = pi_dly[PIPE_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            trace_valid <= 1'b0;
            trace_pi    <= '0;
            trace_po    <= '0;
        end else begin
            trace_valid <= cmp_valid;
            trace_pi    <= cmp_valid ? pi_tap : '0;
            trace_po    <= cmp_valid ? po_approx_i : '0;
        end
    end
`else
    assign trace_valid = 1'b0;
    assign trace_pi    = '0;
    assign trace_po    = '0;
`endif

endmodule

// File: tb/tb_partition_sweep_checker.sv
// tb_partition_sweep_checker
//
// Directed bench for partition_sweep_checker. There are three instances:
//   u0  defaults; the partitions are combinational functions of pi_o, and
//       mode0 selects which function is used
//   u1  PIPE_LAT=2; both partitions are modelled as a 2-cycle registered delay
//   u2  ERR_W=4; the approx response is the bitwise inverse of the exact response
// Inputs change on the falling edge, and outputs are sampled on the falling edge.

module tb_partition_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    logic start2 = 1'b0;
    int   mode0 = 0;

    int checks = 0;
    int errors = 0;

    // ---------------- u0: defaults ----------------
    logic [6:0]  pi0;
    logic [3:0]  pa0, pe0;
    logic        busy0, done0, tv0;
    logic [31:0] err0, flips0;
    logic [3:0]  max0, tpo0;
    logic [6:0]  tpi0;

    always_comb begin
        pe0 = pi0[3:0];
        case (mode0)
            1:       pa0 = pe0 ^ 4'b0001;
            2:       pa0 = 4'b0000;
            default: pa0 = pe0;
        endcase
    end

    partition_sweep_checker u0 (
        .clk(clk), .rst(rst), .start(start0), .pi_o(pi0),
        .po_approx_i(pa0), .po_exact_i(pe0),
        .busy(busy0), .done(done0), .err_count(err0), .bit_flips(flips0),
        .max_abs_err(max0), .trace_valid(tv0), .trace_pi(tpi0), .trace_po(tpo0)
    );

    // ---------------- u1: PIPE_LAT=2 ----------------
    logic [6:0]  pi1;
    logic [6:0]  d1a = '0, d1b = '0;
    logic [3:0]  pa1, pe1;
    logic        busy1, done1, tv1;
    logic [31:0] err1, flips1;
    logic [3:0]  max1, tpo1;
    logic [6:0]  tpi1;

    always @(posedge clk) begin
        d1a <= pi1;
        d1b <= d1a;
    end
    assign pe1 = d1b[3:0];
    assign pa1 = pe1 ^ 4'b1000;

    partition_sweep_checker #(.PIPE_LAT(2)) u1 (
        .clk(clk), .rst(rst), .start(start1), .pi_o(pi1),
        .po_approx_i(pa1), .po_exact_i(pe1),
        .busy(busy1), .done(done1), .err_count(err1), .bit_flips(flips1),
        .max_abs_err(max1), .trace_valid(tv1), .trace_pi(tpi1), .trace_po(tpo1)
    );

    // ---------------- u2: ERR_W=4 ----------------
    logic [6:0]  pi2;
    logic [3:0]  pa2, pe2;
    logic        busy2, done2, tv2;
    logic [3:0]  err2, flips2;
    logic [3:0]  max2, tpo2;
    logic [6:0]  tpi2;

    assign pe2 = pi2[3:0];
    assign pa2 = ~pe2;

    partition_sweep_checker #(.ERR_W(4)) u2 (
        .clk(clk), .rst(rst), .start(start2), .pi_o(pi2),
        .po_approx_i(pa2), .po_exact_i(pe2),
        .busy(busy2), .done(done2), .err_count(err2), .bit_flips(flips2),
        .max_abs_err(max2), .trace_valid(tv2), .trace_pi(tpi2), .trace_po(tpo2)
    );

    // Global watchdog so the bench cannot hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Runs one full default-parameter sweep on u0 and checks the sequence,
    // the done timing and the final metrics. inject_p >= 0 pulses start
    // while pi_o == inject_p (that start must be ignored).
    task automatic run_default_sweep(input int mode, input int exp_err, input int exp_flips,
                                     input int exp_max, input int inject_p, input string tag);
        logic [3:0] exp_tpo;
        mode0 = mode;
        exp_tpo = (mode == 1) ? 4'd1 : 4'd0;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;   // cycle k+1
        checks++;
        if (err0 !== 32'd0 || flips0 !== 32'd0 || max0 !== 4'd0 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL %s_clear: err=%0d flips=%0d max=%0d done=%b, expected 0 0 0 0",
                     tag, err0, flips0, max0, done0);
        end
        for (int p = 0; p < 128; p++) begin
            if (p > 0) @(negedge clk);
            checks++;
            if (pi0 !== 7'(p) || busy0 !== 1'b1 || done0 !== 1'b0) begin
                errors++;
                $display("FAIL %s_seq: p=%0d pi_o=%0d busy=%b done=%b, expected pi_o=%0d busy=1 done=0",
                         tag, p, pi0, busy0, done0, p);
            end
            if (p == 1) begin
                checks++;
`ifdef SWEEP_TRACE_EN
                if (tv0 !== 1'b1 || tpi0 !== 7'd0 || tpo0 !== exp_tpo) begin
                    errors++;
                    $display("FAIL %s_trace: valid=%b pi=%0d po=%0d, expected 1 0 %0d",
                             tag, tv0, tpi0, tpo0, exp_tpo);
                end
`else
                if (tv0 !== 1'b0 || tpi0 !== 7'd0 || tpo0 !== 4'd0) begin
                    errors++;
                    $display("FAIL %s_trace_tied: valid=%b pi=%0d po=%0d, expected 0 0 0 (exp_tpo unused %0d)",
                             tag, tv0, tpi0, tpo0, exp_tpo);
                end
`endif
            end
            start0 = (p == inject_p);
        end
        start0 = 1'b0;
        @(negedge clk);                  // cycle k+129
        checks++;
        if (done0 !== 1'b1 || busy0 !== 1'b0 || pi0 !== 7'd0) begin
            errors++;
            $display("FAIL %s_done_timing: done=%b busy=%b pi_o=%0d, expected done=1 busy=0 pi_o=0",
                     tag, done0, busy0, pi0);
        end
        checks++;
        if (err0 !== 32'(exp_err) || flips0 !== 32'(exp_flips) || max0 !== 4'(exp_max)) begin
            errors++;
            $display("FAIL %s_metrics: err=%0d flips=%0d max=%0d, expected %0d %0d %0d",
                     tag, err0, flips0, max0, exp_err, exp_flips, exp_max);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done0 !== 1'b1 || busy0 !== 1'b0 || err0 !== 32'(exp_err) || flips0 !== 32'(exp_flips)) begin
            errors++;
            $display("FAIL %s_hold: done=%b busy=%b err=%0d flips=%0d, expected 1 0 %0d %0d",
                     tag, done0, busy0, err0, flips0, exp_err, exp_flips);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (pi0 !== 7'd0 || busy0 !== 1'b0 || done0 !== 1'b0 || err0 !== 32'd0 ||
            flips0 !== 32'd0 || max0 !== 4'd0 || tv0 !== 1'b0 || tpi0 !== 7'd0 || tpo0 !== 4'd0) begin
            errors++;
            $display("FAIL reset_u0: pi=%0d busy=%b done=%b err=%0d flips=%0d max=%0d tv=%b, expected all 0",
                     pi0, busy0, done0, err0, flips0, max0, tv0);
        end
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || busy2 !== 1'b0 || done2 !== 1'b0 ||
            err1 !== 32'd0 || err2 !== 4'd0) begin
            errors++;
            $display("FAIL reset_u1u2: busy1=%b done1=%b busy2=%b done2=%b err1=%0d err2=%0d, expected all 0",
                     busy1, done1, busy2, done2, err1, err2);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_exact_match;
        run_default_sweep(0, 0, 0, 0, -1, "match");
    endtask

    task automatic test_start_while_busy;
        run_default_sweep(1, 128, 128, 1, 40, "lsb_flip_busy_start");
    endtask

    task automatic test_restart_in_done;
        run_default_sweep(1, 128, 128, 1, -1, "restart_done");
    endtask

    task automatic test_zero_approx;
        run_default_sweep(2, 120, 256, 15, -1, "zero_approx");
    endtask

    task automatic test_pipe_lat;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;   // cycle k+1
        for (int c = 1; c <= 130; c++) begin
            if (c > 1) @(negedge clk);
            if (c <= 128) begin
                checks++;
                if (pi1 !== 7'(c - 1) || busy1 !== 1'b1 || done1 !== 1'b0) begin
                    errors++;
                    $display("FAIL lat_seq: c=%0d pi_o=%0d busy=%b done=%b, expected pi_o=%0d busy=1 done=0",
                             c, pi1, busy1, done1, c - 1);
                end
            end else begin
                checks++;
                if (busy1 !== 1'b1 || done1 !== 1'b0) begin
                    errors++;
                    $display("FAIL lat_drain: c=%0d busy=%b done=%b, expected busy=1 done=0",
                             c, busy1, done1);
                end
            end
            if (c == 3) begin
                checks++;
                if (err1 !== 32'd0) begin
                    errors++;
                    $display("FAIL lat_first_uncounted: err=%0d expected 0", err1);
                end
            end
            if (c == 4) begin
                checks++;
                if (err1 !== 32'd1 || flips1 !== 32'd1) begin
                    errors++;
                    $display("FAIL lat_first_count: err=%0d flips=%0d expected 1 1", err1, flips1);
                end
            end
        end
        @(negedge clk);                  // cycle k+131
        checks++;
        if (done1 !== 1'b1 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL lat_done_timing: done=%b busy=%b expected 1 0", done1, busy1);
        end
        checks++;
        if (err1 !== 32'd128 || flips1 !== 32'd128 || max1 !== 4'd8) begin
            errors++;
            $display("FAIL lat_metrics: err=%0d flips=%0d max=%0d, expected 128 128 8",
                     err1, flips1, max1);
        end
    endtask

    task automatic test_saturation;
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;   // cycle k+1
        for (int c = 1; c <= 128; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 4) begin
                checks++;
                if (err2 !== 4'd3 || flips2 !== 4'd12) begin
                    errors++;
                    $display("FAIL sat_pre: err=%0d flips=%0d expected 3 12", err2, flips2);
                end
            end
            if (c == 5) begin
                checks++;
                if (err2 !== 4'd4 || flips2 !== 4'd15) begin
                    errors++;
                    $display("FAIL sat_flips: err=%0d flips=%0d expected 4 15", err2, flips2);
                end
            end
        end
        @(negedge clk);                  // cycle k+129
        checks++;
        if (done2 !== 1'b1 || err2 !== 4'd15 || flips2 !== 4'd15 || max2 !== 4'd15) begin
            errors++;
            $display("FAIL sat_final: done=%b err=%0d flips=%0d max=%0d, expected 1 15 15 15",
                     done2, err2, flips2, max2);
        end
    endtask

    task automatic test_reset_mid_sweep;
        bit reached;
        reached = 1'b0;
        mode0 = 1;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            if (pi0 === 7'd50) reached = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL rst_mid_reach: pi_o=%0d never reached 50", pi0);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (pi0 !== 7'd0 || busy0 !== 1'b0 || done0 !== 1'b0 || err0 !== 32'd0 ||
            flips0 !== 32'd0 || max0 !== 4'd0 || tv0 !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_clear: pi=%0d busy=%b done=%b err=%0d flips=%0d max=%0d, expected all 0",
                     pi0, busy0, done0, err0, flips0, max0);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (pi0 !== 7'd0 || busy0 !== 1'b0 || done0 !== 1'b0 || err0 !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_idle: pi=%0d busy=%b done=%b err=%0d, expected 0 0 0 0",
                     pi0, busy0, done0, err0);
        end
        run_default_sweep(1, 128, 128, 1, -1, "after_rst");
    endtask

    initial begin
        test_reset();
        test_exact_match();
        test_start_while_busy();
        test_restart_in_done();
        test_zero_approx();
        test_pipe_lat();
        test_saturation();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
